// File: rtl/fx_bus_pkg.sv
// fx_bus_pkg: shared fx bus widths, opcodes and state encodings.
// Optional feature macro: FX_MST_WR_ACK_EN (write-acknowledge byte and ACK state).
package fx_bus_pkg;

   localparam int FX_AW     = 22;
   localparam int FX_DEV_HI = 21;
   localparam int FX_DEV_LO = 16;
   localparam int FX_DEV_W  = FX_DEV_HI - FX_DEV_LO + 1;

   localparam logic [7:0] OP_WR = 8'h57;
   localparam logic [7:0] OP_RD = 8'h52;
`ifdef FX_MST_WR_ACK_EN
   localparam logic [7:0] ACK_BYTE = 8'hAA;
`endif

   typedef logic [FX_AW-1:0] fx_addr_t;

   // Frame assembly states, owned by the command parser.
   typedef enum logic [2:0] {
      P_IDLE,
      P_ADDR2,
      P_ADDR1,
      P_ADDR0,
      P_DATA
   } parse_state_e;

   // Strobe and response sequencing states, owned by the master.
   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD,
      S_RD_WAIT,
`ifdef FX_MST_WR_ACK_EN
      S_RESP,
      S_ACK
`else
      S_RESP
`endif
   } seq_state_e;

   // Device id occupies the top field; A2[7:6] never reach the bus.
   function automatic fx_addr_t fx_make_addr(input logic [FX_DEV_W-1:0] dev,
                                             input logic [7:0]          addr_hi,
                                             input logic [7:0]          addr_lo);
      return {dev, addr_hi, addr_lo};
   endfunction

endpackage

// File: rtl/fx_bus_master_if.sv
// fx_bus_master_if: command stream, response stream and fx bus signals.
// master = fx_bus_master side, slave = host/slave side.
interface fx_bus_master_if;
   import fx_bus_pkg::*;

   logic [7:0] cmd_data;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] resp_data;
   logic       resp_valid;
   logic       resp_ready;
   fx_addr_t   fx_waddr;
   logic       fx_wr;
   logic [7:0] fx_data;
   fx_addr_t   fx_raddr;
   logic       fx_rd;
   logic [7:0] fx_q;
   logic [7:0] err_cnt;

   modport master (
      input  cmd_data, cmd_valid, resp_ready, fx_q,
      output cmd_ready, resp_data, resp_valid, fx_waddr, fx_wr, fx_data,
             fx_raddr, fx_rd, err_cnt
   );

   modport slave (
      output cmd_data, cmd_valid, resp_ready, fx_q,
      input  cmd_ready, resp_data, resp_valid, fx_waddr, fx_wr, fx_data,
             fx_raddr, fx_rd, err_cnt
   );

endinterface

// File: rtl/fx_cmd_parser.sv
// fx_cmd_parser: takes the command byte stream, assembles write/read frames
// and counts dropped opcode bytes (saturating). frame_done pulses in the
// cycle of the last byte handshake, with frame_addr/frame_data valid then.
module fx_cmd_parser
   import fx_bus_pkg::*;
(
   input  logic       clk_sys,
   input  logic       rst_n,
   input  logic [7:0] cmd_data,
   input  logic       cmd_valid,
   input  logic       cmd_ready,
   output logic       frame_done,
   output logic       frame_wr,
   output fx_addr_t   frame_addr,
   output logic [7:0] frame_data,
   output logic [7:0] err_cnt
);

   parse_state_e         state, state_nxt;
   logic                 is_wr;
   logic [FX_DEV_W-1:0]  dev_id;
   logic [7:0]           addr_hi;
   logic [7:0]           addr_lo;
   logic                 xfer;
   logic                 bad_op;

   assign xfer = cmd_valid && cmd_ready;

   // Next frame position and completion/error pulses for this cycle's byte.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_nxt  = state;
      frame_done = 1'b0;
      bad_op     = 1'b0;
      if (xfer) begin
         case (state)
            P_IDLE: begin
               if (cmd_data == OP_WR || cmd_data == OP_RD) state_nxt = P_ADDR2;
               else                                        bad_op    = 1'b1;
            end
            P_ADDR2: state_nxt = P_ADDR1;
            P_ADDR1: state_nxt = P_ADDR0;
            P_ADDR0: begin
               if (is_wr) begin
                  state_nxt = P_DATA;
               end else begin
                  state_nxt  = P_IDLE;
                  frame_done = 1'b1;
               end
            end
            P_DATA: begin
               state_nxt  = P_IDLE;
               frame_done = 1'b1;
            end
            default: state_nxt = P_IDLE;
         endcase
      end
   end

   // A read completes on A0, so the low address byte comes straight off the bus.
   assign frame_wr   = is_wr;
   assign frame_addr = fx_make_addr(dev_id, addr_hi,
                                    (state == P_ADDR0) ? cmd_data : addr_lo);
   assign frame_data = cmd_data;

   // Frame field registers and the saturating bad-opcode counter.
   always_ff @(posedge clk_sys) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state   <= P_IDLE;
         is_wr   <= 1'b0;
         dev_id  <= '0;
         addr_hi <= '0;
         addr_lo <= '0;
         err_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (xfer) begin
            case (state)
               P_IDLE:  is_wr   <= (cmd_data == OP_WR);
               P_ADDR2: dev_id  <= cmd_data[FX_DEV_W-1:0];
               P_ADDR1: addr_hi <= cmd_data;
               P_ADDR0: addr_lo <= cmd_data;
               default: ;
            endcase
         end
         if (bad_op && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/fx_bus_master.sv
// fx_bus_master: turns parsed command frames into single-cycle fx write/read
// strobes and returns read data as a response byte.
// Optional feature macro: FX_MST_WR_ACK_EN (each write returns one 8'hAA byte).
module fx_bus_master
   import fx_bus_pkg::*;
(
   input  logic             clk_sys,
   input  logic             rst_n,
   fx_bus_master_if.master  bus
);

   seq_state_e  state, state_nxt;
   logic        frame_done;
   logic        frame_wr;
   fx_addr_t    frame_addr;
   logic [7:0]  frame_data;

   // Bytes flow only while nothing is in flight, and never while in reset.
   assign bus.cmd_ready = rst_n && (state == S_IDLE);

   fx_cmd_parser u_parser (
      .clk_sys    (clk_sys),
      .rst_n      (rst_n),
      .cmd_data   (bus.cmd_data),
      .cmd_valid  (bus.cmd_valid),
      .cmd_ready  (bus.cmd_ready),
      .frame_done (frame_done),
      .frame_wr   (frame_wr),
      .frame_addr (frame_addr),
      .frame_data (frame_data),
      .err_cnt    (bus.err_cnt)
   );

   // Strobe/response sequencing and the strobes decoded from it.
   always_comb begin
      state_nxt      = state;
      bus.fx_wr      = 1'b0;
      bus.fx_rd      = 1'b0;
      bus.resp_valid = 1'b0;
      case (state)
         S_IDLE: begin
            if (frame_done) state_nxt = frame_wr ? S_WR : S_RD;
         end
         S_WR: begin
            bus.fx_wr = 1'b1;
`ifdef FX_MST_WR_ACK_EN
            state_nxt = S_ACK;
`else
            state_nxt = S_IDLE;
`endif
         end
         S_RD: begin
            bus.fx_rd = 1'b1;
            state_nxt = S_RD_WAIT;
         end
         S_RD_WAIT: state_nxt = S_RESP;
         S_RESP: begin
            bus.resp_valid = 1'b1;
            if (bus.resp_ready) state_nxt = S_IDLE;
         end
`ifdef FX_MST_WR_ACK_EN
         S_ACK: begin
            bus.resp_valid = 1'b1;
            if (bus.resp_ready) state_nxt = S_IDLE;
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register plus address/data/response holding registers.
   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         bus.fx_waddr  <= '0;
         bus.fx_data   <= '0;
         bus.fx_raddr  <= '0;
         bus.resp_data <= '0;
      end else begin
         state <= state_nxt;
         if (frame_done && frame_wr) begin
            bus.fx_waddr <= frame_addr;
            bus.fx_data  <= frame_data;
         end
         if (frame_done && !frame_wr) bus.fx_raddr <= frame_addr;
         // Slaves present read data the cycle after the strobe.
         if (state == S_RD_WAIT) bus.resp_data <= bus.fx_q;
`ifdef FX_MST_WR_ACK_EN
         if (state == S_WR) bus.resp_data <= ACK_BYTE;
`endif
      end
   end

endmodule

// File: tb/tb_fx_bus_master.sv
// tb_fx_bus_master: randomized and directed bench for fx_bus_master with a
// frame-level reference model (expected strobe/response events and err_cnt).
module tb_fx_bus_master;

   typedef logic [7:0] byte_q_t[$];
   typedef struct {
      int          kind;   // 0 = fx_wr pulse, 1 = fx_rd pulse, 2 = response rise
      logic [21:0] addr;
      logic [7:0]  data;
      int          cyc;
   } ev_t;

   logic clk_sys = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   exp_err  = 0;
   int   both_high = 0;
   logic prev_rv  = 1'b0;
   logic rand_rdy = 1'b0;
   ev_t  act_q[$];
   ev_t  exp_q[$];

   fx_bus_master_if bus ();

   fx_bus_master dut (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   // Register slave: data is a fixed mix of the address, one cycle after fx_rd.
   function automatic logic [7:0] slave_val(input logic [21:0] a);
      return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]};
   endfunction

   always @(posedge clk_sys) bus.fx_q <= bus.fx_rd ? slave_val(bus.fx_raddr) : 8'h00;

   // Record strobes and response rises with their cycle numbers.
   always @(negedge clk_sys) begin
      if (bus.fx_wr === 1'b1) act_q.push_back(ev_t'{0, bus.fx_waddr, bus.fx_data, cyc});
      if (bus.fx_rd === 1'b1) act_q.push_back(ev_t'{1, bus.fx_raddr, 8'h00, cyc});
      if (bus.resp_valid === 1'b1 && prev_rv !== 1'b1)
         act_q.push_back(ev_t'{2, 22'h0, bus.resp_data, cyc});
      if (bus.fx_wr === 1'b1 && bus.fx_rd === 1'b1) both_high <= both_high + 1;
      prev_rv <= bus.resp_valid;
   end

   task automatic tick();
      @(negedge clk_sys);
      if (rand_rdy) bus.resp_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic idle(input int n);
      bus.cmd_valid = 1'b0;
      repeat (n) tick();
   endtask

   // Offer one byte; hs is the cycle in which it is accepted.
   task automatic send_byte(input logic [7:0] b, output int hs);
      int n = 0;
      bus.cmd_data  = b;
      bus.cmd_valid = 1'b1;
      while (bus.cmd_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) begin
         checks++;
         failures++;
         $display("FAIL send_byte_timeout byte=%h", b);
         hs = -1;
      end else begin
         hs = cyc;
      end
      tick();
   endtask

   task automatic send_seq(input byte_q_t bytes, output int first_hs, output int last_hs);
      int h;
      first_hs = -1;
      last_hs  = -1;
      foreach (bytes[i]) begin
         send_byte(bytes[i], h);
         if (i == 0) first_hs = h;
         last_hs = h;
      end
   endtask

   function automatic logic [7:0] rand_bad();
      logic [7:0] b;
      do b = 8'($urandom); while (b == 8'h57 || b == 8'h52);
      return b;
   endfunction

   task automatic send_bad(input logic [7:0] b);
      int h;
      send_byte(b, h);
      if (exp_err < 255) exp_err++;
   endtask

   // Reference model: expected events of one complete frame.
   task automatic model_frame(input bit wr, input logic [21:0] addr,
                              input logic [7:0] d, input int last_hs);
      if (wr) begin
         exp_q.push_back(ev_t'{0, addr, d, last_hs + 1});
`ifdef FX_MST_WR_ACK_EN
         exp_q.push_back(ev_t'{2, 22'h0, 8'hAA, last_hs + 2});
`endif
      end else begin
         exp_q.push_back(ev_t'{1, addr, 8'h00, last_hs + 1});
         exp_q.push_back(ev_t'{2, 22'h0, slave_val(addr), last_hs + 3});
      end
   endtask

   task automatic send_frame(input bit wr, input logic [21:0] addr, input logic [7:0] d,
                             output int first_hs, output int last_hs);
      int h;
      send_byte(wr ? 8'h57 : 8'h52, first_hs);
      send_byte({2'($urandom), addr[21:16]}, h);
      send_byte(addr[15:8], h);
      send_byte(addr[7:0], last_hs);
      if (wr) send_byte(d, last_hs);
      model_frame(wr, addr, d, last_hs);
   endtask

   task automatic compare_events(input string name);
      checks++;
      if (act_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL %s_event_count got=%0d want=%0d", name, act_q.size(), exp_q.size());
      end
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (act_q[i].kind != exp_q[i].kind || act_q[i].addr !== exp_q[i].addr ||
             act_q[i].data !== exp_q[i].data || act_q[i].cyc != exp_q[i].cyc) begin
            failures++;
            $display("FAIL %s_event%0d got kind=%0d addr=%h data=%h cyc=%0d want kind=%0d addr=%h data=%h cyc=%0d",
                     name, i, act_q[i].kind, act_q[i].addr, act_q[i].data, act_q[i].cyc,
                     exp_q[i].kind, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
         end
      end
      act_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      logic [21:0] act[9];
      string       nm[9];
      rst_n          = 1'b0;
      bus.cmd_valid  = 1'b0;
      bus.cmd_data   = 8'h00;
      bus.resp_ready = 1'b1;
      repeat (3) @(negedge clk_sys);
      act[0] = 22'(bus.cmd_ready);  nm[0] = "cmd_ready";
      act[1] = 22'(bus.resp_valid); nm[1] = "resp_valid";
      act[2] = 22'(bus.fx_wr);      nm[2] = "fx_wr";
      act[3] = 22'(bus.fx_rd);      nm[3] = "fx_rd";
      act[4] = bus.fx_waddr;        nm[4] = "fx_waddr";
      act[5] = bus.fx_raddr;        nm[5] = "fx_raddr";
      act[6] = 22'(bus.fx_data);    nm[6] = "fx_data";
      act[7] = 22'(bus.resp_data);  nm[7] = "resp_data";
      act[8] = 22'(bus.err_cnt);    nm[8] = "err_cnt";
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (act[i] !== 22'h0) begin
            failures++;
            $display("FAIL reset_%s got=%h want=0", nm[i], act[i]);
         end
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_cmd_ready got=%b want=1", bus.cmd_ready);
      end
      exp_err = 0;
      @(negedge clk_sys);
      act_q.delete();
   endtask

   task automatic test_write();
      int f, l, want_n;
`ifdef FX_MST_WR_ACK_EN
      want_n = 2;
`else
      want_n = 1;
`endif
      act_q.delete();
      send_seq('{8'h57, 8'h02, 8'h00, 8'h81, 8'h5A}, f, l);
      idle(8);
      checks++;
      if (act_q.size() != want_n) begin
         failures++;
         $display("FAIL write_event_count got=%0d want=%0d", act_q.size(), want_n);
      end
      if (act_q.size() >= 1) begin
         checks++;
         if (act_q[0].kind != 0 || act_q[0].addr !== 22'h020081 ||
             act_q[0].data !== 8'h5A || act_q[0].cyc != l + 1) begin
            failures++;
            $display("FAIL write_pulse got kind=%0d addr=%h data=%h cyc=%0d want kind=0 addr=020081 data=5a cyc=%0d",
                     act_q[0].kind, act_q[0].addr, act_q[0].data, act_q[0].cyc, l + 1);
         end
      end
`ifdef FX_MST_WR_ACK_EN
      if (act_q.size() >= 2) begin
         checks++;
         if (act_q[1].kind != 2 || act_q[1].data !== 8'hAA || act_q[1].cyc != l + 2) begin
            failures++;
            $display("FAIL write_ack got kind=%0d data=%h cyc=%0d want kind=2 data=aa cyc=%0d",
                     act_q[1].kind, act_q[1].data, act_q[1].cyc, l + 2);
         end
      end
`endif
      checks++;
      if (bus.fx_waddr !== 22'h020081 || bus.fx_data !== 8'h5A) begin
         failures++;
         $display("FAIL write_hold got addr=%h data=%h want addr=020081 data=5a",
                  bus.fx_waddr, bus.fx_data);
      end
      act_q.delete();
   endtask

   task automatic test_read();
      int f, l;
      act_q.delete();
      send_seq('{8'h52, 8'h02, 8'h00, 8'h00}, f, l);
      idle(8);
      checks++;
      if (act_q.size() != 2) begin
         failures++;
         $display("FAIL read_event_count got=%0d want=2", act_q.size());
      end
      if (act_q.size() >= 2) begin
         checks++;
         if (act_q[0].kind != 1 || act_q[0].addr !== 22'h020000 || act_q[0].cyc != l + 1) begin
            failures++;
            $display("FAIL read_pulse got kind=%0d addr=%h cyc=%0d want kind=1 addr=020000 cyc=%0d",
                     act_q[0].kind, act_q[0].addr, act_q[0].cyc, l + 1);
         end
         checks++;
         if (act_q[1].kind != 2 || act_q[1].data !== 8'h02 || act_q[1].cyc != l + 3) begin
            failures++;
            $display("FAIL read_resp got kind=%0d data=%h cyc=%0d want kind=2 data=02 cyc=%0d",
                     act_q[1].kind, act_q[1].data, act_q[1].cyc, l + 3);
         end
      end
      act_q.delete();
   endtask

   task automatic test_resp_stall();
      int f, l, c, f2, l2;
      logic [7:0] want;
      act_q.delete();
      exp_q.delete();
      bus.resp_ready = 1'b0;
      send_seq('{8'h52, 8'h01, 8'h23, 8'h45}, f, l);
      model_frame(1'b0, 22'h012345, 8'h00, l);
      want = slave_val(22'h012345);
      bus.cmd_data  = 8'h57;
      bus.cmd_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (bus.cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_cmd_ready cyc=%0d got=%b want=0", cyc, bus.cmd_ready);
         end
         if (cyc >= l + 3) begin
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== want) begin
               failures++;
               $display("FAIL stall_resp cyc=%0d got valid=%b data=%h want valid=1 data=%h",
                        cyc, bus.resp_valid, bus.resp_data, want);
            end
         end
      end
      c = cyc;
      bus.resp_ready = 1'b1;
      send_frame(1'b1, 22'h030010, 8'h99, f2, l2);
      checks++;
      if (f2 != c + 1) begin
         failures++;
         $display("FAIL stall_next_frame_start got=%0d want=%0d", f2, c + 1);
      end
      idle(8);
      compare_events("stall");
   endtask

   task automatic test_bad_opcodes();
      int f, l, h;
      send_bad(8'h00);
      send_bad(8'hFF);
      checks++;
      if (bus.err_cnt !== 8'd2) begin
         failures++;
         $display("FAIL bad_err_cnt_two got=%0d want=2", bus.err_cnt);
      end
      send_frame(1'b1, 22'h010203, 8'h44, f, l);
      idle(6);
      compare_events("bad_then_write");
      for (int i = 0; i < 300; i++) begin
         send_byte(rand_bad(), h);
         if (exp_err < 255) exp_err++;
         if (i == 0) f = h;
         if (i == 251) begin
            checks++;
            if (bus.err_cnt !== 8'hFE) begin
               failures++;
               $display("FAIL bad_err_cnt_fe got=%h want=fe", bus.err_cnt);
            end
         end
      end
      l = h;
      checks++;
      if (l - f != 299) begin
         failures++;
         $display("FAIL bad_no_stall got=%0d want=299 cycles", l - f);
      end
      checks++;
      if (bus.err_cnt !== 8'hFF) begin
         failures++;
         $display("FAIL bad_err_cnt_sat got=%h want=ff", bus.err_cnt);
      end
      idle(2);
   endtask

   task automatic test_reset_mid_frame();
      int f, l;
      act_q.delete();
      exp_q.delete();
      send_seq('{8'h52, 8'h02, 8'h00}, f, l);
      rst_n         = 1'b0;
      bus.cmd_valid = 1'b0;
      tick();
      rst_n   = 1'b1;
      exp_err = 0;
      #1;
      checks++;
      if (bus.err_cnt !== 8'h00 || bus.fx_waddr !== 22'h0 || bus.fx_data !== 8'h00 ||
          bus.fx_raddr !== 22'h0 || bus.resp_data !== 8'h00 || bus.cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL midreset_outputs got err=%h waddr=%h data=%h raddr=%h resp=%h ready=%b want all 0, ready=1",
                  bus.err_cnt, bus.fx_waddr, bus.fx_data, bus.fx_raddr, bus.resp_data, bus.cmd_ready);
      end
      idle(6);
      checks++;
      if (act_q.size() != 0) begin
         failures++;
         $display("FAIL midreset_no_events got=%0d want=0", act_q.size());
      end
      act_q.delete();
      send_seq('{8'h52, 8'h02, 8'h00, 8'h00}, f, l);
      model_frame(1'b0, 22'h020000, 8'h00, l);
      idle(6);
      compare_events("after_reset");
   endtask

   task automatic test_back_to_back();
      bit kinds[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      int f[4];
      int l[4];
      int want;
      for (int i = 0; i < 4; i++)
         send_frame(kinds[i], 22'($urandom), 8'($urandom), f[i], l[i]);
      idle(8);
      for (int i = 0; i < 3; i++) begin
`ifdef FX_MST_WR_ACK_EN
         want = kinds[i] ? 3 : 4;
`else
         want = kinds[i] ? 2 : 4;
`endif
         checks++;
         if (f[i+1] - l[i] != want) begin
            failures++;
            $display("FAIL b2b_gap%0d got=%0d want=%0d", i, f[i+1] - l[i], want);
         end
      end
      compare_events("back_to_back");
   endtask

   task automatic test_random();
      int f, l, k;
      rand_rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         k = $urandom_range(0, 4);
         if (k < 2)      send_frame(1'b1, 22'($urandom), 8'($urandom), f, l);
         else if (k < 4) send_frame(1'b0, 22'($urandom), 8'h00, f, l);
         else            repeat ($urandom_range(1, 3)) send_bad(rand_bad());
      end
      rand_rdy       = 1'b0;
      bus.resp_ready = 1'b1;
      idle(10);
      compare_events("random");
      checks++;
      if (bus.err_cnt !== 8'(exp_err)) begin
         failures++;
         $display("FAIL random_err_cnt got=%0d want=%0d", bus.err_cnt, exp_err);
      end
      checks++;
      if (both_high != 0) begin
         failures++;
         $display("FAIL strobes_overlap got=%0d want=0", both_high);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_resp_stall();
      test_bad_opcodes();
      test_reset_mid_frame();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fx_bus_master.md
# fx_bus_master

Command-stream master for the 22-bit fx register bus: accepts framed byte commands from the host-side byte FIFO logic, drives single-cycle fx write and read strobes toward the register slaves, and returns read data as a byte stream. It sits between the USB byte interface and the fx bus fan-out. Every slave on that bus registers its read data one cycle after the read strobe and drives zero otherwise.

## Interface
- OP_WR, 8'h57, opcode byte for a write frame ('W')
- OP_RD, 8'h52, opcode byte for a read frame ('R')
- clk_sys  in  1  system clock; all logic on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- cmd_data  in  8  command byte stream
- cmd_valid  in  1  cmd_data is valid
- cmd_ready  out  1  master accepts cmd_data this cycle
- resp_data  out  8  response byte
- resp_valid  out  1  resp_data is valid
- resp_ready  in  1  consumer accepts resp_data
- fx_waddr  out  22  write address: [21:16] device id, [15:0] register
- fx_wr  out  1  one-cycle write strobe
- fx_data  out  8  write data
- fx_raddr  out  22  read address
- fx_rd  out  1  one-cycle read strobe
- fx_q  in  8  read data from the slaves, valid the cycle after fx_rd
- err_cnt  out  8  saturating count of discarded bad opcodes

## Operation
- Frames, big-endian: write = OP_WR, A2, A1, A0, D. Read = OP_RD, A2, A1, A0. Address = {A2[5:0], A1, A0}; A2[7:6] are ignored.
- A byte transfers when cmd_valid and cmd_ready are both high.
- FSM states:
  - IDLE: cmd_ready=1. OP_WR or OP_RD latches the frame type and goes to ADDR2. Any other byte is dropped, err_cnt increments (saturates at 8'hFF), and the FSM stays in IDLE.
  - ADDR2, ADDR1, ADDR0: cmd_ready=1; each accepted byte fills its address field. After ADDR0 a write goes to DATA and a read goes to RD.
  - DATA: cmd_ready=1; the accepted byte is latched, then WR.
  - WR: cmd_ready=0. fx_wr=1 for exactly one cycle with fx_waddr and fx_data stable, then IDLE (or ACK when FX_MST_WR_ACK_EN is defined).
  - RD: cmd_ready=0. fx_rd=1 for exactly one cycle with fx_raddr stable, then RD_WAIT.
  - RD_WAIT: cmd_ready=0. fx_q is sampled into resp_data at the end of this cycle, then RESP.
  - RESP: resp_valid=1. resp_data is held until resp_ready; on the handshake the FSM returns to IDLE.
- No timeout in the frame states: a partial frame waits indefinitely for bytes.
- fx_waddr, fx_data and fx_raddr hold their last driven values between strobes.
- fx_wr and fx_rd are never high in the same cycle. A new frame is not accepted until the previous one completes.

## Timing
- Reset values: cmd_ready=0 during reset and 1 in the first cycle after it. resp_valid=0, resp_data=0, fx_wr=0, fx_rd=0, fx_waddr=0, fx_raddr=0, fx_data=0, err_cnt=0, state=IDLE.
- Write: fx_wr is high in the cycle after the D byte handshake.
- Read: fx_rd is high in the cycle after the A0 handshake. fx_q is sampled in the following cycle. resp_valid rises in the cycle after that, i.e. 3 cycles after the A0 handshake.
- Reset mid-frame or mid-response discards everything: FSM to IDLE and outputs to their reset values at the next edge.
- Back-to-back frames: with cmd_valid held high, a write frame takes 6 cycles (5 bytes plus WR). A read frame takes 7 cycles plus any resp_ready stall.
- A bad opcode increments err_cnt in the same cycle it is dropped, with no stall.

## Configuration
- FX_MST_WR_ACK_EN
- Defined: WR goes to state ACK, which drives resp_data=8'hAA and resp_valid=1 until resp_ready, then returns to IDLE. Every write produces exactly one response byte.
- Undefined: the ACK state does not exist and writes produce no response.

## Structure
- Shared package fx_bus_pkg holds:
  - fx address width 22 and device-id field [21:16]
  - OP_WR and OP_RD opcode constants
  - ack byte 8'hAA
  - state encoding enum
- One natural sub-module, fx_cmd_parser: byte handshake, frame assembly and err_cnt. The parent owns the strobe and response sequencing.

## Test plan
- Write frame 57 02 00 81 5A -> one fx_wr pulse with fx_waddr=22'h020081 and fx_data=8'h5A, in the cycle after the 5A handshake; fx_rd stays 0.
- Read frame 52 02 00 00, slave model returning 8'h02 → fx_rd pulse with fx_raddr=22'h020000; resp_data=8'h02 with resp_valid high 3 cycles after the 00 handshake.
- Read with resp_ready held low for 10 cycles → resp_data stable, cmd_ready=0 throughout; the next frame is accepted only after the handshake.
- Bytes 00, FF, 57 … → err_cnt=2, and the following write frame executes normally. 300 bad bytes → err_cnt=8'hFF.
- rst_n low for one cycle after the 02 00 bytes of a read → no fx_rd and no resp_valid; a full frame issued afterwards completes correctly.
- With FX_MST_WR_ACK_EN defined, write 57 01 00 80 33 → fx_wr pulse, then resp_data=8'hAA. Without the macro, no response byte.
